cdc_2phase_rx: RTL and testbench

- Receive endpoint of the two-phase (toggle) req/ack CDC handshake. It lives entirely in the destination clock domain.
- It synchronizes the incoming req toggle and captures the bundled data word into a small output buffer. It then returns an ack toggle.
- The captured word is presented on a valid/ready stream with full backpressure. When the buffer is full, ack is withheld, so the source stays busy and no word is dropped.

---
 rtl/cdc_2phase_rx_if.sv | 41 ++++
 rtl/cdc_2phase_rx.sv | 107 ++++++++++
 tb/tb_cdc_2phase_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_2phase_rx_if.sv
// Bundle of the receive-side CDC handshake and output stream signals.
// The master side is the source/consumer environment; the slave side is the receiver.
interface cdc_2phase_rx_if #(
  parameter int data_width = 8,
  parameter int buf_depth  = 2
);

  localparam int cnt_w = $clog2(buf_depth) + 1;

  // Two-phase handshake from/to the source domain.
  logic                  i_req;
  logic [data_width-1:0] i_data;
  logic                  o_ack;

  // Valid/ready output stream.
  logic                  o_valid;
  logic [data_width-1:0] o_data;
  logic                  i_ready;
  logic [cnt_w-1:0]      o_count;

  modport master (
    output i_req,
    output i_data,
    output i_ready,
    input  o_ack,
    input  o_valid,
    input  o_data,
    input  o_count
  );

  modport slave (
    input  i_req,
    input  i_data,
    input  i_ready,
    output o_ack,
    output o_valid,
    output o_data,
    output o_count
  );

endinterface

// File: rtl/cdc_2phase_rx.sv
// Receive endpoint of a two-phase (toggle) req/ack clock-domain crossing.
// The req toggle is synchronized into i_clk, the bundled word is captured into
// a small FIFO, and ack is toggled back. When the FIFO is full the ack is
// withheld, so the source stays busy and no word is ever dropped.
module cdc_2phase_rx #(
  parameter int data_width  = 8,
  parameter int sync_stages = 2,
  parameter int buf_depth   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  cdc_2phase_rx_if.slave        bus
);

  localparam int ptr_w = $clog2(buf_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_count = cnt_w'(buf_depth);

  // Synchronizer chain; only the last stage is used by any logic.
  logic [sync_stages-1:0] sync_q;
  logic                   req_s;

  // Handshake and FIFO state.
  logic                   ack_q, ack_d;
  logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]       count_q, count_d;
  logic [data_width-1:0]  mem_q [buf_depth];

  // Decoded events for the coming edge.
  logic                   pending;
  logic                   capture;
  logic                   pop;
  logic                   not_empty;

  // Shift the asynchronous req toggle through the synchronizer flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], bus.i_req};
    end
  end

  assign req_s = sync_q[sync_stages-1];

  // A toggle is outstanding while the synchronized req differs from our ack.
  // Capture is gated by the registered count only, so a pop in the same cycle
  // as a full FIFO does not admit a word until the following edge.
  assign pending   = req_s ^ ack_q;
  assign not_empty = (count_q != '0);
  assign capture   = pending && (count_q < full_count);
  assign pop       = not_empty && bus.i_ready;

  // Next-state for the ack toggle, pointers and occupancy count.
  always_comb begin
    ack_d    = ack_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (capture) begin
      ack_d    = ~ack_q;
      wr_ptr_d = wr_ptr_q + ptr_w'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_w'(1);
    end

    unique case ({capture, pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // Register handshake and FIFO bookkeeping; reset discards everything pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Store the bundled word; i_data is stable here because the source holds it
  // until it sees the ack we are about to return on this same edge.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  // Outputs come from registered state only; ack leaves straight from its flop.
  assign bus.o_ack   = ack_q;
  assign bus.o_valid = not_empty;
  assign bus.o_data  = mem_q[rd_ptr_q];
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_cdc_2phase_rx.sv
// Directed and randomized bench for cdc_2phase_rx (data_width=8, sync_stages=2, buf_depth=2).
module tb_cdc_2phase_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cdc_2phase_rx_if #(.data_width(DW), .buf_depth(DEPTH)) bus ();

  cdc_2phase_rx #(
    .data_width (DW),
    .sync_stages(2),
    .buf_depth  (DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state for the random stream: words sent but not yet popped.
  logic [DW-1:0] exp_q[$];
  int            sent, rcvd, cyc;
  logic          prev_valid, prev_ready;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] word;
  logic          old_ack;
  logic          exp_bit;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    bus.i_data = w;
    bus.i_req  = ~bus.i_req;
  endtask

  // Wait (bounded) until the receiver has acknowledged the last toggle.
  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (bus.o_ack !== bus.i_req && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.o_ack), 32'(bus.i_req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req   = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(bus.o_ack), 0);
    chk("reset_valid", 32'(bus.o_valid), 0);
    chk("reset_count", 32'(bus.o_count), 0);
    rst = 1'b0;
    tick();

    // Single word: toggle sampled at edge N, capture/ack after edge N+2.
    bus.i_ready = 1'b1;
    send(8'hA5);
    tick();
    chk("single_ack_n", 32'(bus.o_ack), 0);
    chk("single_valid_n", 32'(bus.o_valid), 0);
    tick();
    chk("single_ack_n1", 32'(bus.o_ack), 0);
    tick();
    chk("single_ack_n2", 32'(bus.o_ack), 1);
    chk("single_valid_n2", 32'(bus.o_valid), 1);
    chk("single_data", 32'(bus.o_data), 32'h A5);
    chk("single_count", 32'(bus.o_count), 1);
    tick();
    chk("single_popped_count", 32'(bus.o_count), 0);
    chk("single_popped_valid", 32'(bus.o_valid), 0);

    // Backpressure: fill the buffer, third word must not be acknowledged.
    bus.i_ready = 1'b0;
    send(8'h11);
    wait_ack("bp_ack_11");
    send(8'h22);
    wait_ack("bp_ack_22");
    tick();
    chk("bp_count_full", 32'(bus.o_count), 2);
    chk("bp_data_head", 32'(bus.o_data), 32'h11);
    send(8'h33);
    exp_bit = !bus.i_req;
    repeat (6) begin
      tick();
      chk("bp_no_ack_full", 32'(bus.o_ack), 32'(exp_bit));
      chk("bp_hold_data", 32'(bus.o_data), 32'h11);
      chk("bp_hold_count", 32'(bus.o_count), 2);
    end

    // Release from full: pop on one edge, capture on the next.
    old_ack = bus.o_ack;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("rel_count_after_pop", 32'(bus.o_count), 1);
    chk("rel_data_22", 32'(bus.o_data), 32'h22);
    chk("rel_ack_still_held", 32'(bus.o_ack), 32'(old_ack));
    tick();
    chk("rel_count_refill", 32'(bus.o_count), 2);
    chk("rel_ack_toggled", 32'(bus.o_ack), 32'(bus.i_req));
    bus.i_ready = 1'b1;
    tick();
    chk("rel_data_33", 32'(bus.o_data), 32'h33);
    tick();
    chk("rel_drained", 32'(bus.o_count), 0);

    // Simultaneous capture and pop on the same edge keeps the count at 1.
    bus.i_ready = 1'b0;
    send(8'h44);
    wait_ack("sim_ack_44");
    tick();
    chk("sim_count_1", 32'(bus.o_count), 1);
    send(8'h55);
    tick();
    tick();
    chk("sim_pre_data", 32'(bus.o_data), 32'h44);
    chk("sim_pre_count", 32'(bus.o_count), 1);
    bus.i_ready = 1'b1;
    tick();
    chk("sim_count_same", 32'(bus.o_count), 1);
    chk("sim_data_55", 32'(bus.o_data), 32'h55);
    chk("sim_ack", 32'(bus.o_ack), 32'(bus.i_req));
    tick();
    chk("sim_drained", 32'(bus.o_count), 0);

    // Random stream: 64 words paced by ack, random ready, checked against a FIFO model.
    bus.i_ready = 1'b0;
    sent = 0;
    rcvd = 0;
    cyc = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    while (rcvd < 64 && cyc < 5000) begin
      if (prev_valid && !prev_ready) begin
        chk("rnd_hold_valid", 32'(bus.o_valid), 1);
        chk("rnd_hold_data", 32'(bus.o_data), 32'(prev_data));
      end
      chk("rnd_count_le_depth", 32'(bus.o_count <= DEPTH), 1);
      if (bus.o_valid) begin
        if (exp_q.size() == 0) chk("rnd_unexpected_word", 32'(bus.o_data), 32'hFFFF_FFFF);
        else chk("rnd_order", 32'(bus.o_data), 32'(exp_q[0]));
      end
      bus.i_ready = 1'($urandom_range(0, 1));
      if (bus.o_valid && bus.i_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        rcvd++;
      end
      if (sent < 64 && bus.o_ack === bus.i_req && $urandom_range(0, 3) != 0) begin
        word = DW'($urandom);
        send(word);
        exp_q.push_back(word);
        sent++;
      end
      prev_valid = bus.o_valid;
      prev_ready = bus.i_ready;
      prev_data  = bus.o_data;
      tick();
      cyc++;
    end
    chk("rnd_all_received", 32'(rcvd), 64);
    bus.i_ready = 1'b1;
    repeat (8) tick();
    chk("rnd_final_empty", 32'(bus.o_count), 0);

    // Mid-operation reset: full buffer plus a pending toggle, reset between edges.
    bus.i_ready = 1'b0;
    send(8'h66);
    wait_ack("mr_ack_66");
    send(8'h77);
    wait_ack("mr_ack_77");
    tick();
    send(8'h88);
    tick();
    chk("mr_count_full", 32'(bus.o_count), 2);
    #2;
    rst = 1'b1;
    bus.i_req = 1'b0;
    #1;
    chk("mr_valid_async", 32'(bus.o_valid), 0);
    chk("mr_count_async", 32'(bus.o_count), 0);
    chk("mr_ack_async", 32'(bus.o_ack), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mr_still_empty", 32'(bus.o_count), 0);
    send(8'h5A);
    wait_ack("mr_ack_5a");
    chk("mr_data_5a", 32'(bus.o_data), 32'h5A);
    chk("mr_count_1", 32'(bus.o_count), 1);
    chk("mr_valid_1", 32'(bus.o_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
